// File: rtl/axi4_lite_reg_slice_if.sv
`default_nettype none
// ============================================================================
// axi4_if : AXI4-Lite bundle with manager / subordinate views
// Revision 1.0
// ============================================================================
interface axi4_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                awprot;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                arprot;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport manager (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport subordinate (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_reg_slice.sv
`default_nettype none
// ============================================================================
// axi4_lite_reg_slice : AXI4-Lite slice, per-channel modes + outstanding limit
// Revision 1.0
// ============================================================================
module axi4_lite_reg_slice_chan #(
    parameter int MODE  = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gate_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);
    generate
        if (MODE == 0) begin : g_bypass
            logic w_unused;
            // Valid is gated alongside ready so downstream never sees a beat upstream did not send
            assign out_valid_o = in_valid_i & gate_i;
            assign in_ready_o  = out_ready_i & gate_i;
            assign out_data_o  = in_data_i;
            assign w_unused    = clk ^ rst_n;
        end else if (MODE == 2) begin : g_fwd
            logic             out_valid_q;
            logic [WIDTH-1:0] out_data_q;
            logic             free_w;
            logic             in_hs_w;

            assign free_w      = !out_valid_q || out_ready_i;
            assign in_ready_o  = free_w & gate_i;
            assign in_hs_w     = in_valid_i & in_ready_o;
            assign out_valid_o = out_valid_q;
            assign out_data_o  = out_data_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                end else if (free_w) begin
                    out_valid_q <= in_hs_w;
                end
            end

            always_ff @(posedge clk) begin
                if (in_hs_w) begin
                    out_data_q <= in_data_i;
                end
            end
        end else begin : g_full
            logic             out_valid_q;
            logic             skid_valid_q;
            logic             ready_q;
            logic [WIDTH-1:0] out_data_q;
            logic [WIDTH-1:0] skid_data_q;
            logic             free_w;
            logic             in_hs_w;

            assign free_w      = !out_valid_q || out_ready_i;
            assign in_ready_o  = ready_q & gate_i;
            assign in_hs_w     = in_valid_i & in_ready_o;
            assign out_valid_o = out_valid_q;
            assign out_data_o  = out_data_q;

            // ready_q tracks the next skid state, so it is low in reset and rises one edge later
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_q  <= 1'b0;
                    skid_valid_q <= 1'b0;
                    ready_q      <= 1'b0;
                end else if (free_w) begin
                    out_valid_q  <= skid_valid_q | in_hs_w;
                    skid_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                end else if (in_hs_w) begin
                    skid_valid_q <= 1'b1;
                    ready_q      <= 1'b0;
                end else begin
                    ready_q      <= !skid_valid_q;
                end
            end

            always_ff @(posedge clk) begin
                if (free_w) begin
                    if (skid_valid_q) begin
                        out_data_q <= skid_data_q;
                    end else if (in_hs_w) begin
                        out_data_q <= in_data_i;
                    end
                end else if (in_hs_w) begin
                    skid_data_q <= in_data_i;
                end
            end
        end
    endgenerate
endmodule

module axi4_lite_reg_slice #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int AW_MODE         = 1,
    parameter int W_MODE          = 1,
    parameter int B_MODE          = 1,
    parameter int AR_MODE         = 1,
    parameter int R_MODE          = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    axi4_if.subordinate                            s_axi,
    axi4_if.manager                                m_axi,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   wr_outstanding,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   rd_outstanding
);
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int AX_W   = ADDR_WIDTH + 3;
    localparam int W_W    = DATA_WIDTH + DATA_WIDTH / 8;
    localparam int R_W    = DATA_WIDTH + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             aw_gate, ar_gate;
    logic             aw_hs, b_hs, ar_hs, r_hs;
    logic [AX_W-1:0]  aw_out, ar_out;
    logic [W_W-1:0]   w_out;
    logic [R_W-1:0]   r_out;

    // Gates use the registered counts, so a same-cycle response unblocks one cycle later
    assign aw_gate = (wr_cnt_q != CNT_MAX);
    assign ar_gate = (rd_cnt_q != CNT_MAX);

    axi4_lite_reg_slice_chan #(.MODE(AW_MODE), .WIDTH(AX_W)) u_aw (
        .clk         (clk),
        .rst_n       (rst_n),
        .gate_i      (aw_gate),
        .in_valid_i  (s_axi.awvalid),
        .in_ready_o  (s_axi.awready),
        .in_data_i   ({s_axi.awprot, s_axi.awaddr}),
        .out_valid_o (m_axi.awvalid),
        .out_ready_i (m_axi.awready),
        .out_data_o  (aw_out)
    );
    assign {m_axi.awprot, m_axi.awaddr} = aw_out;

    axi4_lite_reg_slice_chan #(.MODE(W_MODE), .WIDTH(W_W)) u_w (
        .clk         (clk),
        .rst_n       (rst_n),
        .gate_i      (1'b1),
        .in_valid_i  (s_axi.wvalid),
        .in_ready_o  (s_axi.wready),
        .in_data_i   ({s_axi.wstrb, s_axi.wdata}),
        .out_valid_o (m_axi.wvalid),
        .out_ready_i (m_axi.wready),
        .out_data_o  (w_out)
    );
    assign {m_axi.wstrb, m_axi.wdata} = w_out;

    axi4_lite_reg_slice_chan #(.MODE(B_MODE), .WIDTH(2)) u_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .gate_i      (1'b1),
        .in_valid_i  (m_axi.bvalid),
        .in_ready_o  (m_axi.bready),
        .in_data_i   (m_axi.bresp),
        .out_valid_o (s_axi.bvalid),
        .out_ready_i (s_axi.bready),
        .out_data_o  (s_axi.bresp)
    );

    axi4_lite_reg_slice_chan #(.MODE(AR_MODE), .WIDTH(AX_W)) u_ar (
        .clk         (clk),
        .rst_n       (rst_n),
        .gate_i      (ar_gate),
        .in_valid_i  (s_axi.arvalid),
        .in_ready_o  (s_axi.arready),
        .in_data_i   ({s_axi.arprot, s_axi.araddr}),
        .out_valid_o (m_axi.arvalid),
        .out_ready_i (m_axi.arready),
        .out_data_o  (ar_out)
    );
    assign {m_axi.arprot, m_axi.araddr} = ar_out;

    axi4_lite_reg_slice_chan #(.MODE(R_MODE), .WIDTH(R_W)) u_r (
        .clk         (clk),
        .rst_n       (rst_n),
        .gate_i      (1'b1),
        .in_valid_i  (m_axi.rvalid),
        .in_ready_o  (m_axi.rready),
        .in_data_i   ({m_axi.rresp, m_axi.rdata}),
        .out_valid_o (s_axi.rvalid),
        .out_ready_i (s_axi.rready),
        .out_data_o  (r_out)
    );
    assign {s_axi.rresp, s_axi.rdata} = r_out;

    assign aw_hs = s_axi.awvalid & s_axi.awready;
    assign b_hs  = s_axi.bvalid  & s_axi.bready;
    assign ar_hs = s_axi.arvalid & s_axi.arready;
    assign r_hs  = s_axi.rvalid  & s_axi.rready;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (aw_hs && !b_hs) begin
            wr_cnt_d = wr_cnt_q + CNT_ONE;
        end else if (!aw_hs && b_hs && wr_cnt_q != '0) begin
            wr_cnt_d = wr_cnt_q - CNT_ONE;
        end
        if (ar_hs && !r_hs) begin
            rd_cnt_d = rd_cnt_q + CNT_ONE;
        end else if (!ar_hs && r_hs && rd_cnt_q != '0) begin
            rd_cnt_d = rd_cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign wr_outstanding = wr_cnt_q;
    assign rd_outstanding = rd_cnt_q;

`ifndef SYNTHESIS
    // A response with nothing in flight is a manager/subordinate protocol error
    assert property (@(posedge clk) disable iff (!rst_n) !(b_hs && wr_cnt_q == '0));
    assert property (@(posedge clk) disable iff (!rst_n) !(r_hs && rd_cnt_q == '0));
`endif
endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_reg_slice.sv
`default_nettype none
// ============================================================================
// tb_axi4_lite_reg_slice : scoreboard bench for axi4_lite_reg_slice
// Revision 1.0
// ============================================================================
module tb_axi4_lite_reg_slice;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) sa (), ma (), sb (), mb ();
    logic [3:0] wa_wr, wa_rd;
    logic [1:0] wb_wr, wb_rd;

    // dut_a: every channel in full mode; dut_b: mixed modes with a tight limit
    axi4_lite_reg_slice #(.MAX_OUTSTANDING(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_axi(sa), .m_axi(ma),
        .wr_outstanding(wa_wr), .rd_outstanding(wa_rd)
    );
    axi4_lite_reg_slice #(.AW_MODE(0), .W_MODE(2), .B_MODE(1), .AR_MODE(2), .R_MODE(0),
                          .MAX_OUTSTANDING(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_axi(sb), .m_axi(mb),
        .wr_outstanding(wb_wr), .rd_outstanding(wb_rd)
    );

    localparam int CH_A_AR = 0, CH_A_W = 1, CH_A_R = 2, CH_B_AW = 3;
    localparam int CH_B_W  = 4, CH_B_B = 5, CH_B_AR = 6, CH_B_R = 7;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] q [8][$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void push(input int ch, input logic [63:0] v);
        q[ch].push_back(v);
    endfunction

    function automatic void sb_pop(input int ch, input string name, input logic [63:0] act);
        if (q[ch].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got unexpected beat %0h, expected none", name, act);
        end else begin
            chk(name, act, q[ch].pop_front());
        end
    endfunction

    always @(negedge clk) begin
        if (ma.arvalid && ma.arready) sb_pop(CH_A_AR, "a_m_ar", {ma.arprot, ma.araddr});
        if (ma.wvalid  && ma.wready)  sb_pop(CH_A_W,  "a_m_w",  {ma.wstrb, ma.wdata});
        if (sa.rvalid  && sa.rready)  sb_pop(CH_A_R,  "a_s_r",  {sa.rresp, sa.rdata});
        if (mb.awvalid && mb.awready) sb_pop(CH_B_AW, "b_m_aw", {mb.awprot, mb.awaddr});
        if (mb.wvalid  && mb.wready)  sb_pop(CH_B_W,  "b_m_w",  {mb.wstrb, mb.wdata});
        if (sb.bvalid  && sb.bready)  sb_pop(CH_B_B,  "b_s_b",  {62'd0, sb.bresp});
        if (mb.arvalid && mb.arready) sb_pop(CH_B_AR, "b_m_ar", {mb.arprot, mb.araddr});
        if (sb.rvalid  && sb.rready)  sb_pop(CH_B_R,  "b_s_r",  {sb.rresp, sb.rdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        logic hs;
        {sa.awvalid, sa.awaddr, sa.awprot, sa.wvalid, sa.wdata, sa.wstrb, sa.bready} = '0;
        {sa.arvalid, sa.araddr, sa.arprot, sa.rready} = '0;
        {ma.awready, ma.wready, ma.bvalid, ma.bresp, ma.arready, ma.rvalid, ma.rdata, ma.rresp} = '0;
        {sb.awvalid, sb.awaddr, sb.awprot, sb.wvalid, sb.wdata, sb.wstrb, sb.bready} = '0;
        {sb.arvalid, sb.araddr, sb.arprot, sb.rready} = '0;
        {mb.awready, mb.wready, mb.bvalid, mb.bresp, mb.arready, mb.rvalid, mb.rdata, mb.rresp} = '0;
        #1 rst_n = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_awready", sa.awready, 0);
        chk("rst_a_arready", sa.arready, 0);
        chk("rst_a_m_arvalid", ma.arvalid, 0);
        chk("rst_a_wr_cnt", wa_wr, 0);
        chk("rst_b_s_bvalid", sb.bvalid, 0);
        chk("rst_b_rd_cnt", wb_rd, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("rel_a_wready_low", sa.wready, 0);
        tick();
        chk("rel_a_wready_high", sa.wready, 1);

        // Mixed modes: write then read back, latencies 0/1/1/1/0
        mb.awready = 1; mb.wready = 1; mb.arready = 1; sb.bready = 1; sb.rready = 1;
        sb.awvalid = 1; sb.awaddr = 32'h20; sb.awprot = 3'b010;
        sb.wvalid = 1; sb.wdata = 32'hDEADBEEF; sb.wstrb = 4'b0101;
        push(CH_B_AW, {29'd0, 3'b010, 32'h20});
        push(CH_B_W, {28'd0, 4'b0101, 32'hDEADBEEF});
        @(negedge clk);
        chk("mix_aw_lat0", mb.awvalid, 1);
        chk("mix_w_not_yet", mb.wvalid, 0);
        chk("mix_s_wready", sb.wready, 1);
        tick();
        sb.awvalid = 0; sb.wvalid = 0;
        @(negedge clk);
        chk("mix_w_lat1", mb.wvalid, 1);
        chk("mix_aw_done", mb.awvalid, 0);
        chk("mix_wr_cnt1", wb_wr, 1);
        tick();
        mb.bvalid = 1; mb.bresp = 2'b00;
        push(CH_B_B, 64'd0);
        @(negedge clk);
        chk("mix_b_not_yet", sb.bvalid, 0);
        chk("mix_m_bready", mb.bready, 1);
        tick();
        mb.bvalid = 0;
        @(negedge clk);
        chk("mix_b_lat1", sb.bvalid, 1);
        tick();
        @(negedge clk);
        chk("mix_wr_cnt0", wb_wr, 0);
        tick();
        sb.arvalid = 1; sb.araddr = 32'h20; sb.arprot = 3'b001;
        push(CH_B_AR, {29'd0, 3'b001, 32'h20});
        @(negedge clk);
        chk("mix_ar_not_yet", mb.arvalid, 0);
        tick();
        sb.arvalid = 0;
        @(negedge clk);
        chk("mix_ar_lat1", mb.arvalid, 1);
        tick();
        // Bytes 0 and 2 of 0xDEADBEEF survive the 0101 strobe
        mb.rvalid = 1; mb.rdata = 32'h00AD00EF; mb.rresp = 2'b00;
        push(CH_B_R, {30'd0, 2'b00, 32'h00AD00EF});
        @(negedge clk);
        chk("mix_r_lat0", sb.rvalid, 1);
        chk("mix_rd_cnt1", wb_rd, 1);
        tick();
        mb.rvalid = 0;
        @(negedge clk);
        chk("mix_rd_cnt0", wb_rd, 0);

        // Limit of 2: third AW held until one B returns
        tick();
        sb.bready = 0; sb.awvalid = 1; sb.awprot = 3'b000;
        sb.awaddr = 32'h100; push(CH_B_AW, 64'h100);
        @(negedge clk);
        chk("lim_aw1_ready", sb.awready, 1);
        tick();
        sb.awaddr = 32'h104; push(CH_B_AW, 64'h104);
        @(negedge clk);
        chk("lim_aw2_ready", sb.awready, 1);
        tick();
        sb.awaddr = 32'h108;
        @(negedge clk);
        chk("lim_aw3_blocked", sb.awready, 0);
        chk("lim_m_awvalid_gated", mb.awvalid, 0);
        chk("lim_wr_cnt2", wb_wr, 2);
        tick();
        mb.bvalid = 1; mb.bresp = 2'b10;
        @(negedge clk);
        chk("lim_m_bready", mb.bready, 1);
        chk("lim_still_blocked", sb.awready, 0);
        tick();
        mb.bvalid = 0; sb.bready = 1;
        push(CH_B_B, 64'd2);
        @(negedge clk);
        chk("lim_s_bvalid", sb.bvalid, 1);
        chk("lim_same_cycle_block", sb.awready, 0);
        tick();
        sb.bready = 0;
        push(CH_B_AW, 64'h108);
        @(negedge clk);
        chk("lim_aw3_accept", sb.awready, 1);
        chk("lim_wr_cnt1", wb_wr, 1);
        tick();
        sb.awvalid = 0;
        @(negedge clk);
        chk("lim_wr_cnt2b", wb_wr, 2);

        // Full mode: 8 back-to-back AR beats
        tick();
        ma.arready = 1;
        for (int i = 0; i < 8; i++) begin
            sa.arvalid = 1; sa.araddr = 32'(i * 4);
            push(CH_A_AR, 64'(i * 4));
            @(negedge clk);
            chk("b2b_s_arready", sa.arready, 1);
            chk("b2b_m_arvalid", ma.arvalid, (i > 0));
            tick();
        end
        sa.arvalid = 0;
        @(negedge clk);
        chk("b2b_m_arvalid_last", ma.arvalid, 1);
        tick();
        @(negedge clk);
        chk("b2b_m_arvalid_end", ma.arvalid, 0);
        chk("b2b_rd_cnt8", wa_rd, 8);

        tick();
        rst_n = 0;
        #3 rst_n = 1;
        tick();
        tick();

        // Simultaneous AR and R handshakes at rd_outstanding = 1
        sa.arvalid = 1; sa.araddr = 32'h40;
        push(CH_A_AR, 64'h40);
        tick();
        sa.arvalid = 0;
        ma.rvalid = 1; ma.rdata = 32'h12345678; ma.rresp = 2'b01;
        push(CH_A_R, {30'd0, 2'b01, 32'h12345678});
        @(negedge clk);
        chk("simul_rd_cnt1", wa_rd, 1);
        chk("simul_m_rready", ma.rready, 1);
        tick();
        ma.rvalid = 0;
        sa.rready = 1; sa.arvalid = 1; sa.araddr = 32'h44;
        push(CH_A_AR, 64'h44);
        @(negedge clk);
        chk("simul_s_rvalid", sa.rvalid, 1);
        chk("simul_s_arready", sa.arready, 1);
        tick();
        sa.rready = 0; sa.arvalid = 0;
        @(negedge clk);
        chk("simul_rd_cnt_hold", wa_rd, 1);

        // W burst with a 3-cycle downstream stall
        tick();
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            sa.wvalid = (idx < 6);
            sa.wdata  = 32'hA0 + 32'(idx);
            sa.wstrb  = 4'hF;
            ma.wready = !(c >= 3 && c < 6);
            @(negedge clk);
            if (c == 3) chk("stall_m_wvalid", ma.wvalid, 1);
            if (c == 3) chk("stall_wready_first", sa.wready, 1);
            if (c == 4) chk("stall_wready_drop", sa.wready, 0);
            if (c == 6) chk("stall_wready_skid", sa.wready, 0);
            if (c == 7) chk("stall_wready_back", sa.wready, 1);
            hs = sa.wvalid && sa.wready;
            if (hs) push(CH_A_W, {28'd0, 4'hF, sa.wdata});
            tick();
            if (hs) idx++;
        end
        chk("stall_beats", 64'(idx), 6);

        // Reset pulse while the W skid is full
        sa.wvalid = 1; sa.wdata = 32'hB0; ma.wready = 0;
        tick();
        sa.wdata = 32'hB1;
        @(negedge clk);
        chk("rp_wready_pre", sa.wready, 1);
        tick();
        sa.wvalid = 0;
        @(negedge clk);
        chk("rp_skid_full", sa.wready, 0);
        chk("rp_m_wvalid", ma.wvalid, 1);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("rp_m_wvalid_clr", ma.wvalid, 0);
        chk("rp_wready_clr", sa.wready, 0);
        chk("rp_rd_cnt_clr", wa_rd, 0);
        chk("rp_m_arvalid_clr", ma.arvalid, 0);
        #4 rst_n = 1;
        #1;
        chk("rp_rel_wready_low", sa.wready, 0);
        chk("rp_rel_awready_low", sa.awready, 0);
        tick();
        chk("rp_rel_wready_high", sa.wready, 1);
        chk("rp_rel_arready_high", sa.arready, 1);
        chk("rp_beat_dropped", ma.wvalid, 0);
        ma.wready = 1;
        repeat (3) tick();

        for (int ch = 0; ch < 8; ch++) begin
            chk("queue_empty", 64'(q[ch].size()), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
